// File: rtl/sr_bank_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_writer_if
// Description : Request handshake, SR-bank drive/readback and status bundle
//               for sr_bank_writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_bank_writer_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_in;
    logic             done;
    logic             err;
    logic [RW-1:0]    retries;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_mask,
        input  q_in,
        output req_ready,
        output s_out,
        output r_out,
        output done,
        output err,
        output retries
    );

    modport master (
        output req_valid,
        output req_data,
        output req_mask,
        output q_in,
        input  req_ready,
        input  s_out,
        input  r_out,
        input  done,
        input  err,
        input  retries
    );
endinterface
`default_nettype wire

// File: rtl/sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_writer
// Description : Masked write controller for an SR flip-flop bank with
//               one-cycle s/r excitation, readback verify and bounded retry.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sr_bank_writer_if.slave    bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] c_MAX_CNT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_m;
    logic [RW-1:0]    r_cnt;
    logic [RW-1:0]    r_retries;

    logic             w_accept;
    logic             w_mismatch;
    logic             w_ready;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_r;
    logic             w_done;
    logic             w_err;

    // Only masked bits take part in verification.
    assign w_mismatch = |((bus.q_in ^ r_d) & r_m);
    assign w_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.req_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_d       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_retries <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_d   <= bus.req_data;
                        r_m   <= bus.req_mask;
                        r_cnt <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch && (r_cnt != c_MAX_CNT)) begin
                        r_cnt <= r_cnt + RW'(1);
                    end
                end
                S_DONE, S_ERROR: begin
                    r_retries <= r_cnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        w_s    = '0;
        w_r    = '0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Set and reset lines come from complementary data, so S=R=1 is impossible.
                w_s    = r_m & r_d;
                w_r    = r_m & ~r_d;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (!w_mismatch) begin
                    w_next = S_DONE;
                end else if (r_cnt != c_MAX_CNT) begin
                    w_next = S_DRIVE;
                end else begin
                    w_next = S_ERROR;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERROR: begin
                w_err  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = w_ready;
    assign bus.s_out     = w_s;
    assign bus.r_out     = w_r;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
    assign bus.retries   = r_retries;
endmodule
`default_nettype wire

// File: tb/tb_sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_bank_writer
// Description : Directed self-checking bench for sr_bank_writer with a
//               behavioural SR bank model and readback forcing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_bank_writer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic mon_en;

    logic [7:0] bank;
    logic       bank_load;
    logic [7:0] bank_val;
    logic       q_force;
    logic [7:0] q_val;

    sr_bank_writer_if #(.WIDTH(8), .MAX_RETRY(3)) bus ();

    sr_bank_writer #(.WIDTH(8), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_load) bank <= bank_val;
        else           bank <= (bank & ~bus.r_out) | bus.s_out;
    end

    assign bus.q_in = q_force ? q_val : bank;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((bus.s_out & bus.r_out) !== 8'h00) begin
                errors++;
                $display("FAIL sr_overlap s_out=%h r_out=%h required s&r=00", bus.s_out, bus.r_out);
            end
            checks++;
            if ((bus.done & bus.err) !== 1'b0) begin
                errors++;
                $display("FAIL done_err_both done=%b err=%b required not both high", bus.done, bus.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [7:0] v);
        bank_load = 1'b1;
        bank_val  = v;
        tick();
        bank_load = 1'b0;
    endtask

    // Leaves the bench one cycle into DRIVE.
    task automatic start_req(input logic [7:0] data, input logic [7:0] mask);
        bus.req_data  = data;
        bus.req_mask  = mask;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got=%b required=0", bus.req_ready);
        end
        checks++;
        if ({bus.s_out, bus.r_out} !== 16'h0000) begin
            errors++; $display("FAIL rst_sr got s=%h r=%h required 00/00", bus.s_out, bus.r_out);
        end
        checks++;
        if ({bus.done, bus.err} !== 2'b00 || bus.retries !== 2'd0) begin
            errors++; $display("FAIL rst_status got done=%b err=%b retries=%0d required 0/0/0", bus.done, bus.err, bus.retries);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready got=%b required=1", bus.req_ready);
        end
    endtask

    task automatic run_to_end(input int force_k, output int lat, output int pulses,
                              output bit got_done, output bit got_err);
        lat = 0; pulses = 1; got_done = 0; got_err = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (force_k >= 0) q_force = (k == force_k);
            if (bus.s_out !== 8'h00 || bus.r_out !== 8'h00) pulses++;
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                lat = k + 1; got_done = bus.done; got_err = bus.err;
                break;
            end
        end
    endtask

    task automatic test_clean();
        int lat, pulses; bit gd, ge;
        load_bank(8'h00);
        start_req(8'hA5, 8'hFF);
        checks++;
        if (bus.s_out !== 8'hA5 || bus.r_out !== 8'h5A || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL clean_drive got s=%h r=%h ready=%b required A5/5A/0", bus.s_out, bus.r_out, bus.req_ready);
        end
        run_to_end(-1, lat, pulses, gd, ge);
        checks++;
        if (!gd || ge || lat != 3 || pulses != 1) begin
            errors++; $display("FAIL clean_done got done=%b err=%b lat=%0d pulses=%0d required 1/0/3/1", gd, ge, lat, pulses);
        end
        checks++;
        if (bus.q_in !== 8'hA5) begin
            errors++; $display("FAIL clean_bank got=%h required=A5", bus.q_in);
        end
        tick();
        checks++;
        if (bus.retries !== 2'd0 || bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL clean_after got retries=%0d done=%b ready=%b required 0/0/1", bus.retries, bus.done, bus.req_ready);
        end
    endtask

    task automatic test_masked();
        int lat, pulses; bit gd, ge;
        load_bank(8'hFF);
        start_req(8'h00, 8'h0F);
        checks++;
        if (bus.s_out !== 8'h00 || bus.r_out !== 8'h0F) begin
            errors++; $display("FAIL mask_drive got s=%h r=%h required 00/0F", bus.s_out, bus.r_out);
        end
        run_to_end(-1, lat, pulses, gd, ge);
        checks++;
        if (!gd || lat != 3) begin
            errors++; $display("FAIL mask_done got done=%b lat=%0d required 1/3", gd, lat);
        end
        checks++;
        if (bus.q_in !== 8'hF0) begin
            errors++; $display("FAIL mask_bank got=%h required=F0", bus.q_in);
        end
        tick();
    endtask

    task automatic test_retry();
        int lat, pulses; bit gd, ge;
        load_bank(8'h00);
        q_val = 8'h00;
        start_req(8'h01, 8'h01);
        run_to_end(1, lat, pulses, gd, ge);
        q_force = 1'b0;
        checks++;
        if (!gd || ge || lat != 5 || pulses != 2) begin
            errors++; $display("FAIL retry_done got done=%b err=%b lat=%0d pulses=%0d required 1/0/5/2", gd, ge, lat, pulses);
        end
        tick();
        checks++;
        if (bus.retries !== 2'd1) begin
            errors++; $display("FAIL retry_count got=%0d required=1", bus.retries);
        end
    endtask

    task automatic test_exhaust();
        int lat, pulses; bit gd, ge;
        load_bank(8'h00);
        q_force = 1'b1;
        q_val   = 8'h00;
        start_req(8'h80, 8'h80);
        checks++;
        if (bus.s_out !== 8'h80 || bus.r_out !== 8'h00) begin
            errors++; $display("FAIL exh_drive got s=%h r=%h required 80/00", bus.s_out, bus.r_out);
        end
        run_to_end(-1, lat, pulses, gd, ge);
        checks++;
        if (gd || !ge || lat != 9 || pulses != 4) begin
            errors++; $display("FAIL exh_err got done=%b err=%b lat=%0d pulses=%0d required 0/1/9/4", gd, ge, lat, pulses);
        end
        tick();
        q_force = 1'b0;
        checks++;
        if (bus.retries !== 2'd3 || bus.err !== 1'b0) begin
            errors++; $display("FAIL exh_after got retries=%0d err=%b required 3/0", bus.retries, bus.err);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        load_bank(8'h00);
        start_req(8'hA5, 8'hFF);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.s_out, bus.r_out} !== 16'h0000 || bus.req_ready !== 1'b0 ||
                {bus.done, bus.err} !== 2'b00) begin
                errors++; $display("FAIL midrst_hold%0d got s=%h r=%h ready=%b done=%b err=%b required 00/00/0/0/0",
                                   i, bus.s_out, bus.r_out, bus.req_ready, bus.done, bus.err);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.retries !== 2'd0) begin
            errors++; $display("FAIL midrst_release got ready=%b retries=%0d required 1/0", bus.req_ready, bus.retries);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.s_out !== 8'h00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midrst_quiet got activity_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int ndone, last, badgap, sr_act;
        bus.req_data  = 8'hFF;
        bus.req_mask  = 8'h00;
        bus.req_valid = 1'b1;
        ndone = 0; last = -1; badgap = 0; sr_act = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bus.s_out !== 8'h00 || bus.r_out !== 8'h00) sr_act++;
            if (bus.done === 1'b1) begin
                if (last >= 0 && (k - last) != 4) badgap++;
                if (last < 0 && k != 3) badgap++;
                last = k;
                ndone++;
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (ndone != 4 || badgap != 0) begin
            errors++; $display("FAIL b2b_done got count=%0d bad_spacing=%0d required 4/0", ndone, badgap);
        end
        checks++;
        if (sr_act != 0 || bus.retries !== 2'd0) begin
            errors++; $display("FAIL b2b_sr got sr_cycles=%0d retries=%0d required 0/0", sr_act, bus.retries);
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; mon_en = 1'b0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_data = 8'h00; bus.req_mask = 8'h00;
        bank_load = 1'b0; bank_val = 8'h00; q_force = 1'b0; q_val = 8'h00;
        test_reset();
        test_clean();
        test_masked();
        test_retry();
        test_exhaust();
        test_reset_mid_op();
        test_back_to_back();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish required finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/sr_bank_writer.md
# sr_bank_writer

Write-side controller for a bank of SR flip-flops. Accepts a masked write request over a valid/ready handshake and converts the target word into per-bit set/reset excitation (set, clear or hold, never S=R=1). It pulses the bank's s/r inputs for one clock, reads the bank's q outputs back to verify the write, and retries on mismatch before reporting done or error. It sits between a register-access master and a WIDTH-wide array of sr_ff instances sharing the same clock.

## Interface
- WIDTH, 8, number of SR flip-flops driven (≥1)
- MAX_RETRY, 3, extra drive attempts after the first failed check (≥0)
- RW, $clog2(MAX_RETRY+1) (min 1), width of retry count
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_data  input  WIDTH  target value per bit
- req_mask  input  WIDTH  1 = write this bit, 0 = hold
- s_out  output  WIDTH  set lines to bank
- r_out  output  WIDTH  reset lines to bank
- q_in  input  WIDTH  q outputs of bank (readback)
- done  output  1  one-cycle pulse, write verified
- err  output  1  one-cycle pulse, retries exhausted
- retries  output  RW  retries used by last completed request

## Operation
- States: IDLE, DRIVE, CHECK, DONE, ERROR; state and latched data/mask/retry counter registered.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_data→d, req_mask→m, clear retry counter → DRIVE. req_data/req_mask ignored otherwise.
- DRIVE (one cycle): s_out = m & d; r_out = m & ~d; → CHECK.
- All states except DRIVE: s_out=r_out=0 (bank holds).
- Invariant: (s_out & r_out) == 0 at all times, including reset.
- CHECK (one cycle): mismatch = |((q_in ^ d) & m).
  - no mismatch → DONE
  - mismatch, counter < MAX_RETRY → counter+1 → DRIVE
  - mismatch, counter == MAX_RETRY → ERROR
- DONE: done=1 for exactly one cycle, retries ← counter → IDLE.
- ERROR: err=1 for exactly one cycle, retries ← counter (=MAX_RETRY) → IDLE.
- m == 0: DRIVE issues no s/r, CHECK always passes → DONE with retries=0.
- Unmasked q_in bits never affect the result.
- done and err are never both high.

## Timing
- Reset (rst high at an edge): state→IDLE, d/m/counter/retries→0, done=err=0, s_out=r_out=0. req_ready=0 while rst is high, 1 from the first cycle after rst deasserts.
- Reset mid-operation (DRIVE/CHECK): abandons the request, no done/err pulse, s/r drop to 0 in the next cycle.
- Accept at edge E0: DRIVE in cycle E0→E1 (bank captures at E1), CHECK in E1→E2 (q_in sampled before E2), done high in E2→E3. Clean-write latency is 3 cycles from accept to done.
- Each retry adds 2 cycles. Error pulse lands 3+2·MAX_RETRY cycles after accept.
- req_ready is low from DRIVE through DONE/ERROR. The next accept can occur in the cycle after done/err (IDLE), so peak throughput is one request per 4 cycles.
- q_in is treated as synchronous to clk. No internal synchronizer.

## Test plan
- Reset: hold rst 2 cycles during a DRIVE → s_out=r_out=0, req_ready=0, done=err=0 in the following cycle. req_ready=1 one cycle after release. retries=0.
- Clean write, WIDTH=8: bank reset to 0x00; request data=0xA5, mask=0xFF → DRIVE s_out=0xA5, r_out=0x5A for one cycle. q_in=0xA5 in CHECK, done pulse 3 cycles after accept, retries=0.
- Masked hold: bank=0xFF; request data=0x00, mask=0x0F → s_out=0x00, r_out=0x0F. Bank reads 0xF0, done, upper nibble untouched.
- Retry then pass: bench forces q_in bit0 wrong on the first CHECK only (data=0x01, mask=0x01) → second DRIVE pulse observed, done 5 cycles after accept, retries=1.
- Exhaust, MAX_RETRY=3: q_in stuck at 0, data=0x80, mask=0x80 → 4 DRIVE pulses, err pulse 9 cycles after accept, retries=3, done never high.
- Back-to-back plus assertion: req_valid held high with mask=0x00 → accept every 4 cycles, done each time. Checker on every cycle of all tests: s_out & r_out == 0, and done and err are never high together.
